// File: rtl/text_char_pkg.sv
// Shared constants, FSM encoding and glyph generator for the text character server.
// The glyph table is procedural so the ROM needs no external data file.
package text_char_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam int         BUF_DEPTH   = 512;
  localparam int         FONT_LINES  = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Control codes and space render blank; printable codes get a fixed, line-dependent pattern.
  function automatic logic [7:0] font_glyph_line(input logic [6:0] code, input logic [3:0] line);
    logic [7:0] mix;
    if (code <= 7'h20) return 8'h00;
    mix = ({1'b0, code} * 8'd37) + ({4'h0, line} * 8'd11);
    return mix ^ {line, 4'h0};
  endfunction

endpackage

// File: rtl/font_rom_8x16.sv
// 128-glyph 8x16 font ROM with a registered output; address is {code[6:0], line[3:0]}.
module font_rom_8x16
  import text_char_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  logic [7:0] data_q, data_d;

  always_comb begin
    data_d = font_glyph_line(addr[10:4], addr[3:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= 8'h00;
    else     data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/text_char_server.sv
// 16x32 text buffer with cursor-driven byte writes, clear sweep and a 2-cycle glyph read path.
// Optional cursor blink inversion is enabled by defining TEXT_CURSOR_BLINK_EN.
//
// state   | meaning
// S_CLEAR | sweeping 0x20 into every buffer cell, busy high, writes blocked
// S_IDLE  | accepting bytes on the write port, clear request honoured
module text_char_server
  import text_char_pkg::*;
#(
  parameter int COLS         = 21,
  parameter int ROWS         = 16,
  parameter int BLINK_CYCLES = 32_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] char_xy,
  input  logic [3:0] char_line,
  output logic [7:0] char_pixels,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       clear,
  output logic       busy,
  output logic [8:0] cursor_xy
);

  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [8:0] ADDR_LAST = 9'(BUF_DEPTH - 1);

  state_t     state_q, state_d;
  logic [8:0] clr_addr_q, clr_addr_d;
  logic [3:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic       busy_q, busy_d;
  logic [3:0] row_next;

  logic [7:0] text_mem [BUF_DEPTH];
  logic       mem_we;
  logic [8:0] mem_waddr;
  logic [7:0] mem_wdata;

  logic [6:0] code_q;
  logic [3:0] line_q;
  logic [7:0] glyph_line;

  assign wr_ready  = (state_q == S_IDLE) && !clear;
  assign busy      = busy_q;
  assign cursor_xy = {row_q, col_q};
  assign row_next  = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    row_d      = row_q;
    col_d      = col_q;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    mem_waddr  = {row_q, col_q};
    mem_wdata  = ASCII_SPACE;
    unique case (state_q)
      S_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        clr_addr_d = clr_addr_q + 9'd1;
        busy_d     = 1'b1;
        if (clr_addr_q == ADDR_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          row_d   = 4'd0;
          col_d   = 5'd0;
        end
      end
      S_IDLE: begin
        busy_d = 1'b0;
        if (clear) begin
          state_d    = S_CLEAR;
          clr_addr_d = 9'd0;
          busy_d     = 1'b1;
        end else if (wr_valid) begin
          if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
            mem_we    = 1'b1;
            mem_wdata = wr_data;
            if (col_q == COL_LAST) begin
              col_d = 5'd0;
              row_d = row_next;
            end else begin
              col_d = col_q + 5'd1;
            end
          end else if (wr_data == ASCII_CR) begin
            col_d = 5'd0;
          end else if (wr_data == ASCII_LF) begin
            col_d = 5'd0;
            row_d = row_next;
          end else if (wr_data == ASCII_BS) begin
            if (col_q != 5'd0) begin
              col_d     = col_q - 5'd1;
              mem_we    = 1'b1;
              mem_waddr = {row_q, col_q - 5'd1};
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= 9'd0;
      row_q      <= 4'd0;
      col_q      <= 5'd0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
    end
  end

  // Non-blocking read beside the write gives read-first behaviour on a same-cell collision.
  always_ff @(posedge clk) begin
    if (mem_we) text_mem[mem_waddr] <= mem_wdata;
    code_q <= text_mem[char_xy][6:0];
  end

  always_ff @(posedge clk) begin
    if (rst) line_q <= 4'd0;
    else     line_q <= char_line;
  end

  font_rom_8x16 u_font (
    .clk  (clk),
    .rst  (rst),
    .addr ({code_q, line_q}),
    .data (glyph_line)
  );

`ifdef TEXT_CURSOR_BLINK_EN
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [8:0]  xy_d1_q, xy_d2_q;

  always_comb begin
    blink_cnt_d   = blink_cnt_q + 32'd1;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt_d   = 32'd0;
      blink_phase_d = !blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= 32'd0;
      blink_phase_q <= 1'b0;
      xy_d1_q       <= 9'd0;
      xy_d2_q       <= 9'd0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      xy_d1_q       <= char_xy;
      xy_d2_q       <= xy_d1_q;
    end
  end

  assign char_pixels = (state_q == S_IDLE && blink_phase_q && xy_d2_q == cursor_xy)
                       ? ~glyph_line : glyph_line;
`else
  assign char_pixels = glyph_line;
`endif

endmodule

// File: tb/tb_text_char_server.sv
// Randomized self-checking bench for text_char_server against a behavioural buffer/cursor model.
module tb_text_char_server;

  localparam int COLS = 21;
  localparam int ROWS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] char_xy = '0;
  logic [3:0] char_line = '0;
  logic [7:0] char_pixels;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       clear = 1'b0;
  logic       busy;
  logic [8:0] cursor_xy;

  int vectors = 0;
  int miscompares = 0;

  int m_mem [512];
  int m_row = 0;
  int m_col = 0;

  always #5 clk = ~clk;

  text_char_server #(.COLS(COLS), .ROWS(ROWS), .BLINK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .char_xy(char_xy), .char_line(char_line),
    .char_pixels(char_pixels), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .clear(clear), .busy(busy), .cursor_xy(cursor_xy)
  );

  function automatic int font_ref(input int code, input int line);
    int c;
    c = code % 128;
    if (c <= 32) return 0;
    return ((c * 37 + line * 11) % 256) ^ ((line * 16) % 256);
  endfunction

  function automatic void model_clear();
    foreach (m_mem[i]) m_mem[i] = 32;
    m_row = 0;
    m_col = 0;
  endfunction

  function automatic void model_accept(input int b);
    if (b >= 32 && b <= 126) begin
      m_mem[m_row * 32 + m_col] = b;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
      end
    end else if (b == 13) begin
      m_col = 0;
    end else if (b == 10) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8) begin
      if (m_col > 0) begin
        m_col--;
        m_mem[m_row * 32 + m_col] = 32;
      end
    end
  endfunction

  function automatic logic [8:0] exp_cursor();
    return 9'(m_row * 32 + m_col);
  endfunction

  // Counts busy cycles starting at the current negedge; true 512-cycle sweep expected.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n != 512) begin
      miscompares++;
      $display("FAIL %s busy_len: got %0d cycles, want 512", tag, n);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
    vectors++;
    if (wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_ready_idle: got %b, want 1", wr_ready);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    model_accept(int'(b));
    @(negedge clk);
    vectors++;
    if (cursor_xy !== exp_cursor()) begin
      miscompares++;
      $display("FAIL cursor after 0x%02h: got %03h, want %03h", b, cursor_xy, exp_cursor());
    end
  endtask

  task automatic run_reads(input int n, input bit cell0_lines);
    int exp_q[$];
    logic [8:0] xy;
    logic [3:0] ln;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        vectors++;
        if (char_pixels !== 8'(exp_q[i-2])) begin
          miscompares++;
          $display("FAIL read #%0d: got %02h, want %02h", i - 2, char_pixels, 8'(exp_q[i-2]));
        end
      end
      if (i < n) begin
        if (cell0_lines) begin
          xy = 9'd0;
          ln = 4'(i);
        end else begin
          xy = 9'($urandom_range(0, 511));
          ln = 4'($urandom_range(0, 15));
        end
        char_xy   = xy;
        char_line = ln;
        exp_q.push_back(font_ref(m_mem[xy], int'(ln)));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || wr_ready !== 1'b0 || cursor_xy !== 9'd0 || char_pixels !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_vals: busy=%b rdy=%b cur=%03h pix=%02h, want 1 0 000 00",
               busy, wr_ready, cursor_xy, char_pixels);
    end
    rst = 1'b0;
    count_busy("reset");
    model_clear();
    vectors++;
    if (wr_ready !== 1'b1 || cursor_xy !== 9'd0) begin
      miscompares++;
      $display("FAIL post_sweep: rdy=%b cur=%03h, want 1 000", wr_ready, cursor_xy);
    end
    run_reads(40, 1'b0);
  endtask

  task automatic test_write_read();
    send_byte(8'h41);
    vectors++;
    if (cursor_xy !== 9'h001) begin
      miscompares++;
      $display("FAIL write_A cursor: got %03h, want 001", cursor_xy);
    end
    run_reads(16, 1'b1);
  endtask

  task automatic test_wrap();
    send_byte(8'h0D);
    repeat (COLS) send_byte(8'h58);
    vectors++;
    if (cursor_xy !== 9'h020) begin
      miscompares++;
      $display("FAIL col_wrap: got %03h, want 020", cursor_xy);
    end
    repeat (ROWS - 1) send_byte(8'h0A);
    vectors++;
    if (cursor_xy !== 9'h000) begin
      miscompares++;
      $display("FAIL row_wrap: got %03h, want 000", cursor_xy);
    end
    run_reads(60, 1'b0);
  endtask

  task automatic test_backspace();
    send_byte(8'h08);
    vectors++;
    if (cursor_xy !== 9'h000) begin
      miscompares++;
      $display("FAIL bs_col0: got %03h, want 000", cursor_xy);
    end
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    send_byte(8'h08);
    vectors++;
    if (cursor_xy !== 9'h002) begin
      miscompares++;
      $display("FAIL bs_col3: got %03h, want 002", cursor_xy);
    end
    run_reads(16, 1'b0);
    for (int l = 0; l < 3; l++) begin
      @(negedge clk);
      char_xy = 9'h002;
      char_line = 4'(l + 4);
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (char_pixels !== 8'h00) begin
        miscompares++;
        $display("FAIL bs_cell2: got %02h, want 00", char_pixels);
      end
    end
  endtask

  task automatic test_random_writes();
    logic [7:0] b;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        6:       b = 8'h0D;
        7:       b = 8'h0A;
        8:       b = 8'h08;
        9:       b = 8'($urandom_range(127, 255));
        default: b = 8'($urandom_range(32, 126));
      endcase
      send_byte(b);
    end
    run_reads(200, 1'b0);
  endtask

  task automatic test_clear();
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'h41;
    clear    = 1'b1;
    #1;
    vectors++;
    if (wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_prio wr_ready: got %b, want 0", wr_ready);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    clear    = 1'b0;
    @(negedge clk);
    count_busy("clear");
    model_clear();
    vectors++;
    if (cursor_xy !== 9'h000) begin
      miscompares++;
      $display("FAIL clear_cursor: got %03h, want 000", cursor_xy);
    end
    run_reads(80, 1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    send_byte(8'h5A);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy("rst_mid");
    model_clear();
    run_reads(40, 1'b0);
  endtask

`ifdef TEXT_CURSOR_BLINK_EN
  task automatic test_blink();
    int g, prev, toggles;
    logic inv;
    for (int k = 0; k < 5; k++) send_byte(8'h4D);
    g = font_ref(77, 3);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      char_xy = (pass == 0) ? 9'h005 : 9'h006;
      char_line = 4'd3;
      if (pass == 1) g = font_ref(m_mem[6], 3);
      repeat (3) @(negedge clk);
      toggles = 0;
      prev = -1;
      for (int s = 0; s < 24; s++) begin
        inv = (char_pixels === ~8'(g));
        vectors++;
        if (char_pixels !== 8'(g) && !inv) begin
          miscompares++;
          $display("FAIL blink_val: got %02h, want %02h or inverse", char_pixels, 8'(g));
        end
        if (prev != -1 && int'(inv) != prev) toggles++;
        prev = int'(inv);
        @(negedge clk);
      end
      vectors++;
      if ((pass == 0 && (toggles < 5 || toggles > 6)) || (pass == 1 && toggles != 0)) begin
        miscompares++;
        $display("FAIL blink_toggles at pass %0d: got %0d", pass, toggles);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_backspace();
    test_random_writes();
    test_clear();
    test_reset_mid_sweep();
`ifdef TEXT_CURSOR_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
